instr_queue_dispatcher: RTL

- In-order instruction queue between control_unit and the three execution units: arithmetic, RAM (cache<->main memory) and load/store.
- Buffers the entries control_unit pushes with queue_we, back-pressures it with queue_full, and issues the head entry to the unit matching its type over a valid/ready handshake.
- Tracks in-flight RAM transfers and stalls further RAM issue at a configurable limit.
- Provides a drained indication, which program-complete logic uses to know all issued work has retired.

---
 rtl/instr_queue_dispatcher.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_queue_dispatcher.sv
// instr_queue_dispatcher: in-order instruction queue issuing to arith/RAM/load-store units with RAM credit limit.
// Optional stall counters are enabled by defining QUEUE_STALL_COUNTERS_EN.
module instr_queue_dispatcher #(
  parameter int DEPTH = 8,
  parameter int MAX_RAM_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        queue_we,
  input  logic [1:0]  queue_instr_type,
  input  logic [0:13] queue_arith_instr,
  input  logic [0:8]  queue_ram_instr,
  input  logic [0:9]  queue_ld_st_instr,
  output logic        queue_full,
  output logic        queue_empty,
  output logic        arith_valid,
  output logic [0:13] arith_instr,
  input  logic        arith_ready,
  output logic        ram_valid,
  output logic [0:8]  ram_instr,
  input  logic        ram_ready,
  input  logic        ram_done,
  output logic        ld_st_valid,
  output logic [0:9]  ld_st_instr,
  input  logic        ld_st_ready,
  output logic        drained,
  output logic        err_sticky
`ifdef QUEUE_STALL_COUNTERS_EN
  ,
  output logic [15:0] stall_full_cnt,
  output logic [15:0] stall_ram_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] T_RAM = 2'd0, T_LD_ST = 2'd1, T_ARITH = 2'd2, T_LOOP = 2'd3;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    ram_out;
  logic [15:0]   head;
  logic [1:0]    head_type;
  logic [13:0]   wdata;
  logic          ram_ok, push, pop, ram_pop, ram_dec, err_ev;

  always_comb begin
    head        = mem[rd_ptr];
    head_type   = head[15:14];
    queue_full  = count == (AW+1)'(DEPTH);
    queue_empty = count == '0;
    ram_ok      = ram_out < 4'(MAX_RAM_OUTSTANDING);
    arith_valid = !queue_empty && head_type == T_ARITH;
    ram_valid   = !queue_empty && head_type == T_RAM && ram_ok;
    ld_st_valid = !queue_empty && head_type == T_LD_ST;
    arith_instr = queue_empty ? '0 : head[13:0];
    ram_instr   = queue_empty ? '0 : head[13:5];
    ld_st_instr = queue_empty ? '0 : head[13:4];
    drained     = queue_empty && ram_out == '0;
    ram_pop     = ram_valid && ram_ready;
    pop         = ram_pop || (arith_valid && arith_ready) || (ld_st_valid && ld_st_ready);
    push        = queue_we && !queue_full && queue_instr_type != T_LOOP;
    err_ev      = queue_we && (queue_full || queue_instr_type == T_LOOP);
    ram_dec     = ram_done && ram_out != '0;
    wdata       = queue_instr_type == T_RAM   ? {queue_ram_instr, 5'b0} :
                  queue_instr_type == T_LD_ST ? {queue_ld_st_instr, 4'b0} : queue_arith_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ram_out    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + (AW+1)'(push) - (AW+1)'(pop);
      ram_out <= ram_out + 4'(ram_pop) - 4'(ram_dec);
      if (err_ev) err_sticky <= 1'b1;
    end
  end

  // Storage needs no reset: count gates every read of a stale slot.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {queue_instr_type, wdata};

`ifdef QUEUE_STALL_COUNTERS_EN
  logic ram_blk;
  assign ram_blk = !queue_empty && head_type == T_RAM && !ram_ok;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_full_cnt <= '0;
      stall_ram_cnt  <= '0;
    end else begin
      if (queue_we && queue_full && stall_full_cnt != 16'hFFFF) stall_full_cnt <= stall_full_cnt + 16'd1;
      if (ram_blk && stall_ram_cnt != 16'hFFFF) stall_ram_cnt <= stall_ram_cnt + 16'd1;
    end
  end
`endif
endmodule
